display_scanner: RTL
====================

Name: display_scanner

Overview:
- Parametrised multiplexed 7-segment display driver; successor to the fixed 4-digit anode rotator.
- Time-multiplexes NUM_DIGITS hex digits onto a shared segment bus, with a programmable refresh prescaler, hex-to-segment decode, per-digit enable and decimal points, optional leading-zero blanking, PWM brightness and an anti-ghosting blank guard.
- Sits between the FIR result/status formatting logic and the board's anode and segment pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot; must be a multiple of 2^BRIGHT_W and greater than BLANK_CYC.
- BRIGHT_W, 4: brightness code width.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off (at least 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- value  in  4*NUM_DIGITS  hex nibbles; value[3:0] is digit 0 (rightmost).
- dp  in  NUM_DIGITS  decimal point request per digit.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 forces that digit dark.
- lz_blank  in  1  leading-zero suppression enable.
- brightness  in  BRIGHT_W  0 = off; all-ones = 100 %.
- digit_sel  out  NUM_DIGITS  anode select, active-low, one-hot-low or all ones.
- seg  out  7  segments, active-low; bit 0 = a ... bit 6 = g.
- seg_dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at frame start.

Behaviour:
- State: prescaler p (0..REFRESH_DIV-1) and slot s (0..NUM_DIGITS-1).
  - p increments every clk.
  - At p = REFRESH_DIV-1, p wraps to 0 and s advances; s wraps from NUM_DIGITS-1 to 0.
- Shadow registers (value, dp, digit_en, lz_blank, brightness) load at the end of the cycle where s = 0 and p = 0, including the first cycle after reset.
  - Input changes at any other time have no visible effect until the next frame, so there is no tearing.
- frame_tick is registered. It is high exactly during the cycle where s = 0 and p = 0; upstream may update inputs on it.
- Anode for slot s is asserted (digit_sel[s] = 0, all other bits 1) when all of these hold:
  - p >= BLANK_CYC;
  - digit_en_sh[s] = 1;
  - digit s is not leading-zero suppressed;
  - PWM is on. PWM is on when brightness_sh is all-ones, or when p[BRIGHT_W-1:0] < brightness_sh.
- Otherwise digit_sel is all ones, seg = 7'h7F and seg_dp = 1.
- Leading-zero suppression: with lz_blank_sh = 1, digit k (k >= 1) is suppressed when its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
- Segment decode (active-low, hex digit → seg):
  - 0→40, 1→79, 2→24, 3→30
  - 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03
  - C→46, d→21, E→06, F→0E
- seg_dp = ~dp_sh[s] while the anode is asserted.
- All outputs are registered, one cycle latency: outputs during cycle n+1 reflect (s, p, shadows) of cycle n. The BLANK_CYC >= 1 rule hides the shadow-load boundary.
- Reset (rst_n low, asynchronous, mid-operation included), applied immediately:
  - p = 0, s = 0, shadows = 0;
  - digit_sel all ones, seg = 7'h7F, seg_dp = 1, frame_tick = 0.
- After reset release, scanning restarts at digit 0.
- brightness = 0 or digit_en = 0 keeps the display fully dark while scanning and frame_tick continue.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=16, BRIGHT_W=2, BLANK_CYC=1.
- Reset: hold rst_n low, then release → outputs are dark; frame_tick first high in cycle 1 after release and then every 64 cycles; the anode sequence is 1110, 1101, 1011, 0111, repeating.
- Full brightness: value = 16'h12AF, brightness = 3, digit_en = 4'hF → for 15 of 16 cycles per slot, seg = 0E, 08, 24, 79 for digits 0..3 in turn; dark in the guard cycle.
- PWM: brightness = 1 → anode is low only when p[1:0] = 0 and p >= 1, i.e. 3 cycles per slot (p = 4, 8, 12).
- Leading-zero blanking: value = 16'h0050, lz_blank = 1 → digits 3 and 2 dark, digit 1 shows 12, digit 0 shows 40; with lz_blank = 0, digits 3 and 2 show 40. value = 0 → only digit 0 lit.
- Shadowing and decimal point: change value mid-frame → no change until after the next frame_tick. dp = 4'b0100 → seg_dp low only while digit_sel = 1011.
- Reset mid-slot: assert rst_n at slot 2, p = 7 → outputs go dark with no clock edge; after release, scanning resumes from slot 0.

Source files
------------

// File: rtl/display_scanner_if.sv
// Bundle between the display formatting logic (master) and the 7-segment
// scanner (slave): digit data in, anode/segment pins out.
interface display_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic [6:0]              seg;
  logic                    seg_dp;
  logic                    frame_tick;

  modport master (
    output value, dp, digit_en, lz_blank, brightness,
    input  digit_sel, seg, seg_dp, frame_tick
  );

  modport slave (
    input  value, dp, digit_en, lz_blank, brightness,
    output digit_sel, seg, seg_dp, frame_tick
  );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: prescaled digit rotation, hex decode,
// leading-zero blanking, PWM dimming and a per-slot anti-ghosting guard.
module display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int BLANK_CYC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  display_scanner_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]    P_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    P_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [SEL_W-1:0]    S_LAST  = SEL_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BR_FULL = {BRIGHT_W{1'b1}};

  // Active-low hex font, bit 0 = segment a.
  function automatic logic [6:0] hex7_f(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      p_r;
  logic [SEL_W-1:0]      s_r;
  logic [VAL_W-1:0]      value_sh_r;
  logic [NUM_DIGITS-1:0] dp_sh_r;
  logic [NUM_DIGITS-1:0] en_sh_r;
  logic                  lz_sh_r;
  logic [BRIGHT_W-1:0]   br_sh_r;

  logic [NUM_DIGITS-1:0] digit_sel_r;
  logic [6:0]            seg_r;
  logic                  seg_dp_r;
  logic                  frame_tick_r;

  logic                  frame_start_s;
  logic [NUM_DIGITS-1:0] lz_sup_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_en_s;
  logic                  cur_sup_s;
  logic [NUM_DIGITS-1:0] cur_sel_s;
  logic                  pwm_on_s;
  logic                  lit_s;
  logic [NUM_DIGITS-1:0] sel_nxt_s;
  logic [6:0]            seg_nxt_s;
  logic                  seg_dp_nxt_s;

  assign frame_start_s = (p_r == '0) && (s_r == '0);

  // Prescaler and slot counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0;
      s_r <= '0;
    end else if (p_r == P_LAST) begin
      p_r <= '0;
      if (s_r == S_LAST) begin
        s_r <= '0;
      end else begin
        s_r <= s_r + SEL_W'(1);
      end
    end else begin
      p_r <= p_r + CNT_W'(1);
    end
  end

  // Shadow capture once per frame so a frame is never drawn from mixed data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_sh_r <= '0;
      dp_sh_r    <= '0;
      en_sh_r    <= '0;
      lz_sh_r    <= 1'b0;
      br_sh_r    <= '0;
    end else if (frame_start_s) begin
      value_sh_r <= bus.value;
      dp_sh_r    <= bus.dp;
      en_sh_r    <= bus.digit_en;
      lz_sh_r    <= bus.lz_blank;
      br_sh_r    <= bus.brightness;
    end
  end

  // Leading-zero mask: a digit blanks when it and everything above it is zero.
  always_comb begin : lz_mask
    logic zero_above;
    lz_sup_s   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above & (value_sh_r[4*k +: 4] == 4'h0);
      lz_sup_s[k] = lz_sh_r & zero_above;
    end
  end

  // Pick the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    cur_en_s  = 1'b0;
    cur_sup_s = 1'b0;
    cur_sel_s = {NUM_DIGITS{1'b1}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (s_r == SEL_W'(k)) begin
        cur_nib_s    = value_sh_r[4*k +: 4];
        cur_dp_s     = dp_sh_r[k];
        cur_en_s     = en_sh_r[k];
        cur_sup_s    = lz_sup_s[k];
        cur_sel_s[k] = 1'b0;
      end else begin
        cur_sel_s[k] = 1'b1;
      end
    end
  end

  assign pwm_on_s = (br_sh_r == BR_FULL) || (p_r[BRIGHT_W-1:0] < br_sh_r);
  assign lit_s    = (p_r >= P_BLANK) && cur_en_s && !cur_sup_s && pwm_on_s;

  // Next pin state: either the selected digit or fully dark.
  always_comb begin
    if (lit_s) begin
      sel_nxt_s    = cur_sel_s;
      seg_nxt_s    = hex7_f(cur_nib_s);
      seg_dp_nxt_s = ~cur_dp_s;
    end else begin
      sel_nxt_s    = {NUM_DIGITS{1'b1}};
      seg_nxt_s    = 7'h7F;
      seg_dp_nxt_s = 1'b1;
    end
  end

  // Output registers; the guard cycle at slot start hides the shadow reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_r  <= {NUM_DIGITS{1'b1}};
      seg_r        <= 7'h7F;
      seg_dp_r     <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      digit_sel_r  <= sel_nxt_s;
      seg_r        <= seg_nxt_s;
      seg_dp_r     <= seg_dp_nxt_s;
      frame_tick_r <= frame_start_s;
    end
  end

  assign bus.digit_sel  = digit_sel_r;
  assign bus.seg        = seg_r;
  assign bus.seg_dp     = seg_dp_r;
  assign bus.frame_tick = frame_tick_r;
endmodule
